// File: rtl/lava_seq_ctrl.sv
// Program sequencer for the two-lane LAVA datapath: ROM fetch, operand latch, ALU wait, dual RAM write.
// Optional busy-cycle counter on o_cycle_cnt is enabled by defining LAVA_SEQ_PERF_CNT_EN.
module lava_seq_ctrl #(
  parameter int unsigned RADDR_W  = 3,
  parameter int unsigned WADDR_W  = 4,
  parameter int unsigned PROG_LEN = 8,
  parameter int unsigned ROM_LAT  = 1,
  parameter int unsigned ALU_LAT  = 1,
  parameter logic [3:0]  HALT_OP  = 4'hF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_start,
  input  logic               i_stall,
  output logic               o_busy,
  output logic               o_done,
  output logic [RADDR_W-1:0] o_rom_addr,
  input  logic [35:0]        i_rom_data,
  output logic [3:0]         o_inst,
  output logic [7:0]         o_opa0,
  output logic [7:0]         o_opb0,
  output logic [7:0]         o_opa1,
  output logic [7:0]         o_opb1,
  output logic               o_ram_we,
  output logic [WADDR_W-1:0] o_ram_addra,
  output logic [WADDR_W-1:0] o_ram_addrb,
  output logic [RADDR_W:0]   o_instr_cnt,
  output logic [15:0]        o_cycle_cnt
);

  localparam int unsigned CNT_W   = RADDR_W + 1;
  localparam int unsigned LAT_MAX = (ROM_LAT > ALU_LAT) ? ROM_LAT : ALU_LAT;
  localparam int unsigned DWELL_W = (LAT_MAX > 1) ? $clog2(LAT_MAX) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_LATCH = 3'd2,
    S_EXEC  = 3'd3,
    S_WRITE = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t               r_state;
  logic [DWELL_W-1:0]   r_dwell;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_we;
  logic [RADDR_W-1:0]   r_rom_addr;
  logic [WADDR_W-1:0]   r_wptr;
  logic [WADDR_W-1:0]   r_addrb;
  logic [CNT_W-1:0]     r_instr_cnt;
  logic [3:0]           r_inst;
  logic [7:0]           r_opa0;
  logic [7:0]           r_opb0;
  logic [7:0]           r_opa1;
  logic [7:0]           r_opb1;
  logic                 w_accept;

  assign w_accept = (r_state == S_IDLE) && i_start;

  // Sequencer; lane-1 address is kept as its own register so it resets to 0 with everything else.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_dwell     <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_we        <= 1'b0;
      r_rom_addr  <= '0;
      r_wptr      <= '0;
      r_addrb     <= '0;
      r_instr_cnt <= '0;
      r_inst      <= '0;
      r_opa0      <= '0;
      r_opb0      <= '0;
      r_opa1      <= '0;
      r_opb1      <= '0;
    end else begin
      r_done <= 1'b0;
      r_we   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_state     <= S_FETCH;
            r_busy      <= 1'b1;
            r_dwell     <= '0;
            r_rom_addr  <= '0;
            r_wptr      <= '0;
            r_addrb     <= WADDR_W'(1);
            r_instr_cnt <= '0;
          end
        end
        S_FETCH: begin
          if (!i_stall) begin
            if (r_dwell == DWELL_W'(ROM_LAT - 1)) begin
              r_dwell <= '0;
              r_state <= S_LATCH;
            end else begin
              r_dwell <= r_dwell + DWELL_W'(1);
            end
          end
        end
        S_LATCH: begin
          r_inst <= i_rom_data[35:32];
          r_opa0 <= i_rom_data[31:24];
          r_opb0 <= i_rom_data[23:16];
          r_opa1 <= i_rom_data[15:8];
          r_opb1 <= i_rom_data[7:0];
          r_dwell <= '0;
          if (i_rom_data[35:32] == HALT_OP) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end else begin
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (!i_stall) begin
            if (r_dwell == DWELL_W'(ALU_LAT - 1)) begin
              r_dwell <= '0;
              r_state <= S_WRITE;
              r_we    <= 1'b1;
            end else begin
              r_dwell <= r_dwell + DWELL_W'(1);
            end
          end
        end
        S_WRITE: begin
          if (i_stall) begin
            r_we <= 1'b1;
          end else begin
            r_wptr      <= r_wptr + WADDR_W'(2);
            r_addrb     <= r_addrb + WADDR_W'(2);
            r_instr_cnt <= r_instr_cnt + CNT_W'(1);
            if (r_rom_addr == RADDR_W'(PROG_LEN - 1)) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_rom_addr <= r_rom_addr + RADDR_W'(1);
              r_state    <= S_FETCH;
            end
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef LAVA_SEQ_PERF_CNT_EN
  logic [15:0] r_cycle_cnt;

  // Saturating busy-cycle counter, cleared when a run is accepted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cycle_cnt <= '0;
    end else if (w_accept) begin
      r_cycle_cnt <= '0;
    end else if (r_busy && (r_cycle_cnt != 16'hFFFF)) begin
      r_cycle_cnt <= r_cycle_cnt + 16'd1;
    end
  end

  assign o_cycle_cnt = r_cycle_cnt;
`else
  logic w_unused_accept;
  assign w_unused_accept = w_accept;
  assign o_cycle_cnt     = 16'd0;
`endif

  // A stall must suppress the write strobe in the very cycle it is raised.
  assign o_ram_we    = r_we & ~i_stall;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_rom_addr  = r_rom_addr;
  assign o_inst      = r_inst;
  assign o_opa0      = r_opa0;
  assign o_opb0      = r_opb0;
  assign o_opa1      = r_opa1;
  assign o_opb1      = r_opb1;
  assign o_ram_addra = r_wptr;
  assign o_ram_addrb = r_addrb;
  assign o_instr_cnt = r_instr_cnt;

endmodule

// File: tb/tb_lava_seq_ctrl.sv
// Directed scoreboard bench for lava_seq_ctrl: default build (A) and ROM_LAT=2/ALU_LAT=3/PROG_LEN=2 build (B).
module tb_lava_seq_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic a_start, a_stall, b_start, b_stall;

  logic [35:0] rom_a [0:7];
  logic [35:0] rom_b [0:7];

  logic        a_busy, a_done, a_we, b_busy, b_done, b_we;
  logic [2:0]  a_rom_addr, b_rom_addr;
  logic [35:0] a_rom_data, b_rom_data;
  logic [3:0]  a_inst, b_inst;
  logic [7:0]  a_opa0, a_opb0, a_opa1, a_opb1;
  logic [7:0]  b_opa0, b_opb0, b_opa1, b_opb1;
  logic [3:0]  a_addra, a_addrb, b_addra, b_addrb;
  logic [3:0]  a_instr_cnt, b_instr_cnt;
  logic [15:0] a_cycle_cnt, b_cycle_cnt;

  assign a_rom_data = rom_a[a_rom_addr];
  assign b_rom_data = rom_b[b_rom_addr];

  lava_seq_ctrl u_a (
    .clk(clk), .rst(rst), .i_start(a_start), .i_stall(a_stall),
    .o_busy(a_busy), .o_done(a_done), .o_rom_addr(a_rom_addr), .i_rom_data(a_rom_data),
    .o_inst(a_inst), .o_opa0(a_opa0), .o_opb0(a_opb0), .o_opa1(a_opa1), .o_opb1(a_opb1),
    .o_ram_we(a_we), .o_ram_addra(a_addra), .o_ram_addrb(a_addrb),
    .o_instr_cnt(a_instr_cnt), .o_cycle_cnt(a_cycle_cnt)
  );

  lava_seq_ctrl #(.ROM_LAT(2), .ALU_LAT(3), .PROG_LEN(2)) u_b (
    .clk(clk), .rst(rst), .i_start(b_start), .i_stall(b_stall),
    .o_busy(b_busy), .o_done(b_done), .o_rom_addr(b_rom_addr), .i_rom_data(b_rom_data),
    .o_inst(b_inst), .o_opa0(b_opa0), .o_opb0(b_opb0), .o_opa1(b_opa1), .o_opb1(b_opb1),
    .o_ram_we(b_we), .o_ram_addra(b_addra), .o_ram_addrb(b_addrb),
    .o_instr_cnt(b_instr_cnt), .o_cycle_cnt(b_cycle_cnt)
  );

  // Observation mux: sel=0 watches A, sel=1 watches B.
  logic        sel;
  logic        w_busy, w_done, w_we;
  logic [3:0]  w_addra, w_addrb;
  logic [35:0] w_word;
  logic [69:0] w_all;
  assign w_busy  = sel ? b_busy  : a_busy;
  assign w_done  = sel ? b_done  : a_done;
  assign w_we    = sel ? b_we    : a_we;
  assign w_addra = sel ? b_addra : a_addra;
  assign w_addrb = sel ? b_addrb : a_addrb;
  assign w_word  = sel ? {b_inst, b_opa0, b_opb0, b_opa1, b_opb1}
                       : {a_inst, a_opa0, a_opb0, a_opa1, a_opb1};
  assign w_all   = sel ? {b_busy, b_done, b_rom_addr, b_inst, b_opa0, b_opb0, b_opa1, b_opb1,
                          b_we, b_addra, b_addrb, b_instr_cnt, b_cycle_cnt}
                       : {a_busy, a_done, a_rom_addr, a_inst, a_opa0, a_opb0, a_opa1, a_opb1,
                          a_we, a_addra, a_addrb, a_instr_cnt, a_cycle_cnt};

  typedef struct packed {
    logic [3:0]  addra;
    logic [3:0]  addrb;
    logic [35:0] word;
    logic [31:0] cyc;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected writes for a run: write i lands per*(i+1) cycles after acceptance, plus any stall.
  task automatic push_prog(input bit isb, input int n, input int per, input int stall_idx,
                           input int stall_len);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.addra = 4'(2 * i);
      e.addrb = 4'(2 * i + 1);
      e.word  = isb ? rom_b[i] : rom_a[i];
      e.cyc   = 32'(per * (i + 1) + ((stall_len > 0 && i >= stall_idx) ? stall_len : 0));
      q.push_back(e);
    end
  endtask

  task automatic drive(input logic st, input logic sl);
    if (sel) begin b_start = st; b_stall = sl; end
    else     begin a_start = st; a_stall = sl; end
  endtask

  // Runs a fixed window after pulsing start; cycle c is the state after the c-th edge past acceptance.
  task automatic run(input int max_cyc, input int stall_at, input int stall_len,
                     input int restart_at, input int rst_at,
                     output int n_busy, output int done_cyc, output int n_done);
    exp_t e;
    n_busy = 0; done_cyc = 0; n_done = 0;
    @(negedge clk);
    drive(1'b1, 1'b0);
    for (int c = 1; c <= max_cyc; c++) begin
      @(negedge clk);
      drive(c == restart_at, (stall_len > 0) && (c >= stall_at) && (c < stall_at + stall_len));
      if (c == rst_at) rst = 1'b0;
      #1;
      if (c == rst_at) chk("abort_outputs_zero", 96'(w_all), 96'(0));
      if (w_busy) n_busy++;
      if (w_done) begin n_done++; done_cyc = c; end
      if (w_we) begin
        if (q.size() == 0) begin
          chk("write_expected", 96'(q.size() != 0), 96'(1));
        end else begin
          e = q.pop_front();
          chk("wr_addr_pair", 96'({w_addra, w_addrb}), 96'({e.addra, e.addrb}));
          chk("wr_cycle", 96'(c), 96'(e.cyc));
          chk("wr_operands", 96'(w_word), 96'(e.word));
        end
      end
    end
    drive(1'b0, 1'b0);
  endtask

  int nb, dc, nd;

  initial begin
    rst = 1'b0; sel = 1'b0;
    a_start = 1'b0; a_stall = 1'b0; b_start = 1'b0; b_stall = 1'b0;
    for (int i = 0; i < 8; i++) begin
      rom_a[i] = {4'h0, 8'(8'hA0 + i), 8'(8'hB0 + i), 8'(8'hC0 + i), 8'(8'hD0 + i)};
      rom_b[i] = {4'(i + 1), 8'(8'h10 + i), 8'(8'h20 + i), 8'(8'h30 + i), 8'(8'h40 + i)};
    end
    repeat (3) @(negedge clk);
    chk("reset_a_all_zero", 96'({a_busy, a_done, a_rom_addr, a_inst, a_opa0, a_opb0, a_opa1, a_opb1,
                                 a_we, a_addra, a_addrb, a_instr_cnt, a_cycle_cnt}), 96'(0));
    chk("reset_b_all_zero", 96'({b_busy, b_done, b_rom_addr, b_inst, b_we, b_addra, b_addrb,
                                 b_instr_cnt}), 96'(0));
    @(negedge clk);
    rst = 1'b1;

    // Full default program
    push_prog(1'b0, 8, 4, 0, 0);
    run(45, 0, 0, 0, 0, nb, dc, nd);
    chk("full_busy_cycles", 96'(nb), 96'(33));
    chk("full_done_cycle", 96'(dc), 96'(33));
    chk("full_done_count", 96'(nd), 96'(1));
    chk("full_instr_cnt", 96'(a_instr_cnt), 96'(8));
    chk("full_writes_left", 96'(q.size()), 96'(0));
`ifdef LAVA_SEQ_PERF_CNT_EN
    chk("full_cycle_cnt", 96'(a_cycle_cnt), 96'(33));
`else
    chk("full_cycle_cnt", 96'(a_cycle_cnt), 96'(0));
`endif

    // Halt opcode in word 3
    rom_a[3][35:32] = 4'hF;
    push_prog(1'b0, 3, 4, 0, 0);
    run(25, 0, 0, 0, 0, nb, dc, nd);
    chk("halt_done_cycle", 96'(dc), 96'(15));
    chk("halt_done_count", 96'(nd), 96'(1));
    chk("halt_instr_cnt", 96'(a_instr_cnt), 96'(3));
    chk("halt_writes_left", 96'(q.size()), 96'(0));
    rom_a[3][35:32] = 4'h0;

    // Five-cycle stall over the second WRITE
    push_prog(1'b0, 8, 4, 1, 5);
    run(50, 8, 5, 0, 0, nb, dc, nd);
    chk("stall_busy_cycles", 96'(nb), 96'(38));
    chk("stall_done_cycle", 96'(dc), 96'(38));
    chk("stall_instr_cnt", 96'(a_instr_cnt), 96'(8));
    chk("stall_writes_left", 96'(q.size()), 96'(0));
`ifdef LAVA_SEQ_PERF_CNT_EN
    chk("stall_cycle_cnt", 96'(a_cycle_cnt), 96'(38));
`else
    chk("stall_cycle_cnt", 96'(a_cycle_cnt), 96'(0));
`endif

    // Start re-pulsed mid-run is ignored
    push_prog(1'b0, 8, 4, 0, 0);
    run(45, 0, 0, 10, 0, nb, dc, nd);
    chk("restart_done_count", 96'(nd), 96'(1));
    chk("restart_done_cycle", 96'(dc), 96'(33));
    chk("restart_writes_left", 96'(q.size()), 96'(0));

    // Reset during EXEC of the fourth instruction
    push_prog(1'b0, 8, 4, 0, 0);
    run(25, 0, 0, 0, 15, nb, dc, nd);
    chk("abort_done_count", 96'(nd), 96'(0));
    chk("abort_writes_left", 96'(q.size()), 96'(5));
    q.delete();
    @(negedge clk);
    rst = 1'b1;
    push_prog(1'b0, 8, 4, 0, 0);
    run(45, 0, 0, 0, 0, nb, dc, nd);
    chk("rerun_done_cycle", 96'(dc), 96'(33));
    chk("rerun_instr_cnt", 96'(a_instr_cnt), 96'(8));
    chk("rerun_writes_left", 96'(q.size()), 96'(0));

    // Longer latencies, two-instruction program
    sel = 1'b1;
    push_prog(1'b1, 2, 7, 0, 0);
    run(25, 0, 0, 0, 0, nb, dc, nd);
    chk("lat_busy_cycles", 96'(nb), 96'(15));
    chk("lat_done_cycle", 96'(dc), 96'(15));
    chk("lat_instr_cnt", 96'(b_instr_cnt), 96'(2));
    chk("lat_writes_left", 96'(q.size()), 96'(0));
`ifdef LAVA_SEQ_PERF_CNT_EN
    chk("lat_cycle_cnt", 96'(b_cycle_cnt), 96'(15));
`else
    chk("lat_cycle_cnt", 96'(b_cycle_cnt), 96'(0));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
